mfsk_nco_mod: RTL and testbench

//  Parametrised M-ary FSK modulator; successor to the fixed 2FSK divider/ROM/switch top.

---
 rtl/mfsk_nco_mod.sv | 226 ++++++++++++++++++++++
 tb/tb_mfsk_nco_mod.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfsk_nco_mod.sv
// ============================================================================
// mfsk_nco_mod
// ----------------------------------------------------------------------------
// Parametrised M-ary FSK modulator built around a phase-accumulator NCO.
// Symbols arrive over a valid/ready handshake. Each accepted symbol is held
// for SYM_PERIOD clocks, and its value selects the NCO frequency word
//     fcw = F0_FCW + symbol * STEP_FCW   (mod 2**PHASE_W).
// The top LUT_AW bits of the phase address a full-wave sine table. The table
// is computed at elaboration. Samples are offset-binary, so phase 0 gives
// exact midscale.
//
// A symbol offered on the last cycle of the current symbol follows it with no
// gap. If no symbol is offered on that cycle, the block raises a one-cycle
// underrun pulse and returns to IDLE.
//
// Configuration macro:
//   FSK_PHASE_RESET_EN  defined   : phase is cleared in the cycle after every
//                                   accept (coherent FSK, each symbol starts
//                                   at phase 0).
//                       undefined : continuous-phase FSK (default).
//
// Ports:
//   clk           in   1         sole clock, rising edge
//   rst_n         in   1         asynchronous active-low reset
//   i_sym_valid   in   1         i_sym_data is valid
//   i_sym_data    in   SYM_BITS  symbol value
//   o_sym_ready   out  1         symbol is accepted this cycle if valid
//   o_sym_strobe  out  1         one-cycle pulse on first cycle of a symbol
//   o_code        out  SYM_BITS  symbol currently being transmitted
//   o_busy        out  1         high while transmitting (RUN)
//   o_underrun    out  1         one-cycle pulse: no symbol at boundary
//   o_dout        out  OUT_W     modulated sample, offset-binary
// ============================================================================
module mfsk_nco_mod #(
    parameter int                 PHASE_W    = 24,
    parameter int                 LUT_AW     = 10,
    parameter int                 OUT_W      = 11,
    parameter int                 SYM_BITS   = 1,
    parameter int                 SYM_PERIOD = 2048,
    parameter logic [PHASE_W-1:0] F0_FCW     = 24'h040000,
    parameter logic [PHASE_W-1:0] STEP_FCW   = 24'h040000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_sym_valid,
    input  logic [SYM_BITS-1:0] i_sym_data,
    output logic                o_sym_ready,
    output logic                o_sym_strobe,
    output logic [SYM_BITS-1:0] o_code,
    output logic                o_busy,
    output logic                o_underrun,
    output logic [OUT_W-1:0]    o_dout
);

    localparam int               CNT_W     = $clog2(SYM_PERIOD);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SYM_PERIOD - 1);
    localparam int               LUT_DEPTH = 2 ** LUT_AW;
    localparam int               MID_INT   = 2 ** (OUT_W - 1);
    localparam logic [OUT_W-1:0] MIDSCALE  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam real              PI        = 3.14159265358979323846;
    localparam real              AMP       = real'(MID_INT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  r_fcw;
    logic [CNT_W-1:0]    r_sym_cnt;
    logic [SYM_BITS-1:0] r_code;
    logic                r_strobe;
    logic                r_underrun;
    logic [LUT_AW-1:0]   r_lut_addr;
    logic [OUT_W-1:0]    r_dout;

    state_t              w_state_next;
    logic [PHASE_W-1:0]  w_phase_next;
    logic [PHASE_W-1:0]  w_fcw_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [SYM_BITS-1:0] w_code_next;
    logic                w_strobe_next;
    logic                w_underrun_next;

    logic                w_ready;
    logic                w_accept;
    logic                w_last;
    logic [PHASE_W-1:0]  w_sym_ext;
    logic [PHASE_W-1:0]  w_sym_fcw;
    logic [LUT_AW-1:0]   w_lut_addr;
    logic [OUT_W-1:0]    w_lut [0:LUT_DEPTH-1];

    // ------------------------------------------------------------------------
    // Full-wave sine table, evaluated entirely at elaboration.
    // Rounding is half away from zero, so entry 0 is exactly midscale.
    // ------------------------------------------------------------------------
    for (genvar a = 0; a < LUT_DEPTH; a++) begin : g_lut
        localparam real SAMPLE  = AMP * $sin(2.0 * PI * real'(a) / real'(LUT_DEPTH));
        localparam int  ROUNDED = (SAMPLE >= 0.0) ? $rtoi(SAMPLE + 0.5)
                                                  : $rtoi(SAMPLE - 0.5);
        localparam int  CODE    = MID_INT + ROUNDED;
        assign w_lut[a] = CODE[OUT_W-1:0];
    end

    // Ready does not look at valid. The block can take a symbol when idle or
    // on the final clock of the current symbol.
    assign w_last      = (r_sym_cnt == LAST_CNT);
    assign w_ready     = (r_state == ST_IDLE) | w_last;
    assign w_accept    = i_sym_valid & w_ready;

    // The frequency word is computed in PHASE_W bits, so it wraps naturally.
    assign w_sym_ext   = PHASE_W'(i_sym_data);
    assign w_sym_fcw   = F0_FCW + w_sym_ext * STEP_FCW;

    assign w_lut_addr  = r_phase[PHASE_W-1 -: LUT_AW];

    assign o_sym_ready  = w_ready;
    assign o_sym_strobe = r_strobe;
    assign o_code       = r_code;
    assign o_busy       = (r_state == ST_RUN);
    assign o_underrun   = r_underrun;
    assign o_dout       = r_dout;

    // ------------------------------------------------------------------------
    // Next-state logic for the symbol sequencer and the NCO.
    // In IDLE the phase and the symbol counter are held at zero.
    // In RUN the phase advances by the current frequency word every clock.
    // On the last clock of a symbol, either the next symbol is loaded with
    // no gap or the block falls back to IDLE and flags an underrun.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_phase_next    = r_phase;
        w_fcw_next      = r_fcw;
        w_cnt_next      = r_sym_cnt;
        w_code_next     = r_code;
        w_strobe_next   = 1'b0;
        w_underrun_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_phase_next = '0;
                w_cnt_next   = '0;
                if (w_accept) begin
                    w_state_next  = ST_RUN;
                    w_code_next   = i_sym_data;
                    w_fcw_next    = w_sym_fcw;
                    w_strobe_next = 1'b1;
                end
            end

            ST_RUN: begin
                w_phase_next = r_phase + r_fcw;
                w_cnt_next   = r_sym_cnt + 1'b1;
                if (w_last) begin
                    w_cnt_next = '0;
                    if (w_accept) begin
                        w_code_next   = i_sym_data;
                        w_fcw_next    = w_sym_fcw;
                        w_strobe_next = 1'b1;
`ifdef FSK_PHASE_RESET_EN
                        w_phase_next  = '0;
`else
                        w_phase_next  = r_phase + r_fcw;
`endif
                    end else begin
                        w_state_next    = ST_IDLE;
                        w_phase_next    = '0;
                        w_underrun_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_phase_next = '0;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer state register. Reset returns every field to its power-up
    // value immediately, so an interrupted symbol is never resumed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_fcw      <= '0;
            r_sym_cnt  <= '0;
            r_code     <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= w_phase_next;
            r_fcw      <= w_fcw_next;
            r_sym_cnt  <= w_cnt_next;
            r_code     <= w_code_next;
            r_strobe   <= w_strobe_next;
            r_underrun <= w_underrun_next;
        end
    end

    // ------------------------------------------------------------------------
    // Two-stage output pipeline: registered LUT address, then registered
    // sample. The sample lags the phase by two clocks. While idle, both
    // stages are forced to their midscale values, so the DAC sits at
    // midscale as soon as a run ends.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lut_addr <= '0;
            r_dout     <= MIDSCALE;
        end else if (r_state == ST_IDLE) begin
            r_lut_addr <= '0;
            r_dout     <= MIDSCALE;
        end else begin
            r_lut_addr <= w_lut_addr;
            r_dout     <= w_lut[r_lut_addr];
        end
    end

endmodule

// File: tb/tb_mfsk_nco_mod.sv
// ============================================================================
// tb_mfsk_nco_mod
// ----------------------------------------------------------------------------
// Self-checking bench for mfsk_nco_mod.
// The default instance (2FSK) is tracked by a cycle monitor. For every
// accepted symbol, the stimulus pushes the expected code, frequency word and
// accept cycle into a scoreboard. The monitor pops each entry when the
// strobe is due and predicts the phase and sine samples independently.
// A second instance with SYM_BITS=2 exercises the 4-tone case.
// Honours FSK_PHASE_RESET_EN by expecting phase 0 at every symbol start.
// ============================================================================
module tb_mfsk_nco_mod;

    localparam int          SYM_PERIOD = 2048;
    localparam int          MID        = 1024;
    localparam real         PI         = 3.14159265358979323846;
    localparam logic [23:0] F0         = 24'h040000;
    localparam logic [23:0] STEP       = 24'h040000;

    typedef struct {
        logic [0:0]  code;
        logic [23:0] fcw;
        int          cyc;
    } symEntry_t;

    logic        clk;
    logic        rst_n;
    logic        symValid;
    logic [0:0]  symData;
    logic        symReady;
    logic        symStrobe;
    logic [0:0]  code;
    logic        busy;
    logic        underrun;
    logic [10:0] dout;

    logic        symValid4;
    logic [1:0]  symData4;
    logic        symReady4;
    logic        symStrobe4;
    logic [1:0]  code4;
    logic        busy4;
    logic        underrun4;
    logic [10:0] dout4;

    int          checkCount = 0;
    int          failCount  = 0;
    int          cycCnt     = 0;
    symEntry_t   sbQueue[$];

    int          tbRun;
    int          tbCnt;
    int          idleCnt;
    logic [23:0] tbFcw;
    logic [0:0]  tbCode;
    logic [23:0] prevPhase;
    logic [23:0] hist1;
    logic [23:0] hist2;

    mfsk_nco_mod u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sym_valid  (symValid),
        .i_sym_data   (symData),
        .o_sym_ready  (symReady),
        .o_sym_strobe (symStrobe),
        .o_code       (code),
        .o_busy       (busy),
        .o_underrun   (underrun),
        .o_dout       (dout)
    );

    mfsk_nco_mod #(.SYM_BITS(2)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sym_valid  (symValid4),
        .i_sym_data   (symData4),
        .o_sym_ready  (symReady4),
        .o_sym_strobe (symStrobe4),
        .o_code       (code4),
        .o_busy       (busy4),
        .o_underrun   (underrun4),
        .o_dout       (dout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycCnt = cycCnt + 1;
    end

    // Reference sine sample for a 24-bit phase, 10-bit table, 11-bit output.
    function automatic int sineRef(input logic [23:0] ph);
        int  a;
        real v;
        a = 32'(ph[23:14]);
        v = 1023.0 * $sin(2.0 * PI * real'(a) / 1024.0);
        if (v >= 0.0) return MID + $rtoi(v + 0.5);
        else          return MID + $rtoi(v - 0.5);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d",
                     tag, actual, expected, cycCnt);
        end
    endtask

    // Offer one symbol, wait (bounded) for ready, record the expectation.
    task automatic applyStimulus(input logic [0:0] sym);
        int        guard;
        symEntry_t e;
        guard    = 0;
        symValid = 1'b1;
        symData  = sym;
        while (!symReady && guard < 3 * SYM_PERIOD) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (!symReady) begin
            checkOutput("accept_timeout", 32'(symReady), 32'd1);
            symValid = 1'b0;
            return;
        end
        e.code = sym;
        e.fcw  = F0 + 24'(sym) * STEP;
        e.cyc  = cycCnt;
        sbQueue.push_back(e);
        @(negedge clk);
        symValid = 1'b0;
    endtask

    // Cycle monitor for the default instance.
    initial begin
        symEntry_t   ent;
        logic        expStrobe;
        logic        expUnderrun;
        logic        expReady;
        logic [23:0] curPhase;
        tbRun = 0; tbCnt = 0; idleCnt = 2; tbFcw = '0; tbCode = '0;
        prevPhase = '0; hist1 = '0; hist2 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tbRun = 0; tbCnt = 0; idleCnt = 2; tbFcw = '0;
                prevPhase = '0; hist1 = '0; hist2 = '0;
                sbQueue.delete();
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_dout", 32'(dout), 32'(MID));
            end else begin
                expStrobe   = (sbQueue.size() > 0) && (sbQueue[0].cyc == cycCnt - 1);
                expUnderrun = 1'b0;
                curPhase    = '0;
                if (expStrobe) begin
                    ent = sbQueue.pop_front();
                    curPhase = (tbRun != 0) ? prevPhase + tbFcw : 24'd0;
`ifdef FSK_PHASE_RESET_EN
                    curPhase = '0;
`endif
                    tbRun = 1; tbCnt = 0; idleCnt = 0;
                    tbFcw = ent.fcw; tbCode = ent.code;
                    checkOutput("code_new", 32'(code), 32'(ent.code));
                end else if (tbRun != 0) begin
                    if (tbCnt == SYM_PERIOD - 1) begin
                        tbRun = 0; tbCnt = 0; idleCnt = 0;
                        expUnderrun = 1'b1;
                    end else begin
                        tbCnt    = tbCnt + 1;
                        curPhase = prevPhase + tbFcw;
                    end
                end else if (idleCnt < 2) begin
                    idleCnt = idleCnt + 1;
                end
                expReady = (tbRun == 0) || (tbCnt == SYM_PERIOD - 1);
                checkOutput("strobe",   32'(symStrobe), 32'(expStrobe));
                checkOutput("underrun", 32'(underrun),  32'(expUnderrun));
                checkOutput("busy",     32'(busy),      32'(tbRun != 0));
                checkOutput("ready",    32'(symReady),  32'(expReady));
                if (tbRun != 0) begin
                    checkOutput("dout_run", 32'(dout), 32'(sineRef(hist2)));
                    if (!expStrobe) checkOutput("code_hold", 32'(code), 32'(tbCode));
                end else if (idleCnt >= 2) begin
                    checkOutput("dout_idle", 32'(dout), 32'(MID));
                end
                hist2     = hist1;
                hist1     = curPhase;
                prevPhase = curPhase;
            end
        end
    end

    initial begin
        int          hold;
        logic [23:0] ph4;
        int          exp4;
        rst_n = 1'b0; symValid = 1'b0; symData = '0;
        symValid4 = 1'b0; symData4 = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset values once reset is released.
        checkOutput("t1_dout",     32'(dout),      32'(MID));
        checkOutput("t1_busy",     32'(busy),      32'd0);
        checkOutput("t1_ready",    32'(symReady),  32'd1);
        checkOutput("t1_code",     32'(code),      32'd0);
        checkOutput("t1_underrun", 32'(underrun),  32'd0);
        checkOutput("t1_strobe",   32'(symStrobe), 32'd0);

        $display("[TB] single symbol 0 then underrun");
        applyStimulus(1'b0);
        repeat (SYM_PERIOD + 50) @(negedge clk);

        $display("[TB] back-to-back symbols 1,0,1");
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        repeat (SYM_PERIOD + 50) @(negedge clk);

        $display("[TB] four-tone instance, symbol 3");
        symValid4 = 1'b1; symData4 = 2'd3;
        checkOutput("t4_ready", 32'(symReady4), 32'd1);
        @(negedge clk);
        symValid4 = 1'b0;
        hold = 0;
        for (int k = 0; k < SYM_PERIOD + 50; k++) begin
            if (k == 0) checkOutput("t4_strobe", 32'(symStrobe4), 32'd1);
            if (k < 40) begin
                ph4  = 24'(k - 2) * 24'h100000;
                exp4 = (k < 2) ? MID : sineRef(ph4);
                checkOutput("t4_dout", 32'(dout4), 32'(exp4));
            end
            if (k == SYM_PERIOD) checkOutput("t4_underrun", 32'(underrun4), 32'd1);
            if (busy4 && code4 == 2'd3) hold = hold + 1;
            @(negedge clk);
        end
        checkOutput("t4_hold", 32'(hold), 32'(SYM_PERIOD));

        $display("[TB] reset asserted mid-symbol");
        applyStimulus(1'b1);
        repeat (1000) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_dout",     32'(dout),      32'(MID));
        checkOutput("t5_busy",     32'(busy),      32'd0);
        checkOutput("t5_ready",    32'(symReady),  32'd1);
        checkOutput("t5_code",     32'(code),      32'd0);
        checkOutput("t5_underrun", 32'(underrun),  32'd0);
        checkOutput("t5_strobe",   32'(symStrobe), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1);
        repeat (SYM_PERIOD + 50) @(negedge clk);

        checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
